seq_divider: RTL and testbench

//  Sequential unsigned restoring divider: N / D -> quotient, remainder.

---
 rtl/div_pkg.sv | 11 +
 rtl/div_step.sv | 39 +++
 rtl/seq_divider.sv | 123 ++++++++++++
 tb/tb_seq_divider.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types for the sequential restoring divider.
package div_pkg;

    // Controller states: waiting, iterating, result valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage : div_pkg

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
// Shifts {A,Q} left by one, trial-subtracts the divisor from the upper half.
// If the difference is negative, the shifted value is restored and the
// quotient bit is 0; otherwise the difference is kept and the bit is 1.
module div_step #(
    parameter int n = 8
) (
    input  logic [n:0]   A,
    input  logic [n-1:0] Q,
    input  logic [n:0]   M,
    output logic [n:0]   A_next,
    output logic [n-1:0] Q_next
);

    logic [n:0] t_hi;
    logic [n:0] diff;
    logic       unused_a_msb;

    // A stays below M throughout, so its top bit is always shifted out as 0.
    assign unused_a_msb = A[n];

    // Upper n+1 bits of {A,Q} << 1, then the (n+1)-bit trial subtract.
    always_comb begin
        t_hi = {A[n-1:0], Q[n-1]};
        diff = t_hi - M;
    end

    // Restore mux and new quotient bit (inverted sign of the trial difference).
    always_comb begin
        if (diff[n]) begin
            A_next = t_hi;
            Q_next = {Q[n-2:0], 1'b0};
        end else begin
            A_next = diff;
            Q_next = {Q[n-2:0], 1'b1};
        end
    end

endmodule : div_step

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: N / D -> Quotient, Remainder.
// One quotient bit per clock; a start pulse in IDLE or DONE loads the operands,
// and ready stays high while the registered result is valid.
module seq_divider
    import div_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clock,
    input  logic         n_reset,
    input  logic         start,
    input  logic [n-1:0] N,
    input  logic [n-1:0] D,
    output logic         busy,
    output logic         ready,
    output logic         div0,
    output logic [n-1:0] Quotient,
    output logic [n-1:0] Remainder
);

    localparam int CW = (n > 2) ? $clog2(n) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(n - 1);

    div_state_t   state_q, state_d;
    logic [n:0]   a_q, a_d;
    logic [n-1:0] q_q, q_d;
    logic [n:0]   m_q, m_d;
    logic [CW-1:0] count_q, count_d;
    logic [n-1:0] quot_q, quot_d;
    logic [n-1:0] rem_q, rem_d;
    logic         div0_q, div0_d;

    logic [n:0]   a_step;
    logic [n-1:0] q_step;

    div_step #(.n(n)) u_step (
        .A      (a_q),
        .Q      (q_q),
        .M      (m_q),
        .A_next (a_step),
        .Q_next (q_step)
    );

    // State, datapath and result registers; reset abandons any operation in flight.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            count_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            count_q <= count_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            div0_q  <= div0_d;
        end
    end

    // Next-state logic: accept in IDLE/DONE, iterate in RUN, latch result on the last step.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        count_d = count_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        div0_d  = div0_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = '0;
                    q_d     = N;
                    m_d     = {1'b0, D};
                    count_d = CNT_INIT;
                    if (D == '0) begin
                        // Divide by zero completes immediately with a saturated quotient.
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = N;
                        div0_d  = 1'b1;
                    end else begin
                        // Previous result stays visible until the new one is written.
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                a_d     = a_step;
                q_d     = q_step;
                count_d = count_q - 1'b1;
                if (count_q == '0) begin
                    state_d = DONE;
                    quot_d  = q_step;
                    rem_d   = a_step[n-1:0];
                    div0_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status flags decode straight from the state register.
    always_comb begin
        busy      = (state_q == RUN);
        ready     = (state_q == DONE);
        div0      = div0_q;
        Quotient  = quot_q;
        Remainder = rem_q;
    end

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Directed and randomised checks for seq_divider (n = 8).
module tb_seq_divider;

    logic       clock;
    logic       n_reset;
    logic       start;
    logic [7:0] N;
    logic [7:0] D;
    logic       busy;
    logic       ready;
    logic       div0;
    logic [7:0] Quotient;
    logic [7:0] Remainder;

    int errors = 0;
    int checks = 0;

    seq_divider #(.n(8)) dut (
        .clock     (clock),
        .n_reset   (n_reset),
        .start     (start),
        .N         (N),
        .D         (D),
        .busy      (busy),
        .ready     (ready),
        .div0      (div0),
        .Quotient  (Quotient),
        .Remainder (Remainder)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] nn;
        logic [7:0] dd;
        logic [7:0] q;
        logic [7:0] r;
        logic       d0;
        int         lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // busy and ready must never be high together.
    always @(negedge clock) begin
        if (n_reset && busy && ready) begin
            checks++;
            errors++;
            $display("FAIL busy_ready_exclusive: got busy=1 ready=1 expected not both");
        end
    end

    // Pulse start for one edge, then count edges (accepting edge = 1) until ready.
    task automatic run_op(input logic [7:0] nn, input logic [7:0] dd, output int lat);
        @(negedge clock);
        N = nn;
        D = dd;
        start = 1'b1;
        @(posedge clock);
        lat = 1;
        @(negedge clock);
        start = 1'b0;
        N = 8'($urandom);
        D = 8'($urandom);
        while (!ready && lat < 40) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
    endtask

    int lat;
    logic [7:0] rn, rd;

    initial begin
        vecs[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9};
        vecs[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9};
        vecs[2]  = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 9};
        vecs[3]  = '{8'd200, 8'd0,   8'hFF,  8'd200, 1'b1, 1};
        vecs[4]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 9};
        vecs[5]  = '{8'd0,   8'd13,  8'd0,   8'd0,   1'b0, 9};
        vecs[6]  = '{8'd60,  8'd8,   8'd7,   8'd4,   1'b0, 9};
        vecs[7]  = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0, 9};
        vecs[8]  = '{8'd254, 8'd2,   8'd127, 8'd0,   1'b0, 9};
        vecs[9]  = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1, 1};
        vecs[10] = '{8'd128, 8'd3,   8'd42,  8'd2,   1'b0, 9};
        vecs[11] = '{8'd170, 8'd128, 8'd1,   8'd42,  1'b0, 9};

        n_reset = 1'b0;
        start   = 1'b0;
        N       = 8'd0;
        D       = 8'd0;
        repeat (2) @(negedge clock);
        check("reset_busy", 32'(busy), 0);
        check("reset_ready", 32'(ready), 0);
        check("reset_div0", 32'(div0), 0);
        check("reset_quot", 32'(Quotient), 0);
        check("reset_rem", 32'(Remainder), 0);
        n_reset = 1'b1;

        // Table of single operations.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].nn, vecs[i].dd, lat);
            $display("op %0d/%0d -> q=%0d r=%0d div0=%0d lat=%0d",
                     vecs[i].nn, vecs[i].dd, Quotient, Remainder, div0, lat);
            check("tbl_lat", 32'(lat), 32'(vecs[i].lat));
            check("tbl_quot", 32'(Quotient), 32'(vecs[i].q));
            check("tbl_rem", 32'(Remainder), 32'(vecs[i].r));
            check("tbl_div0", 32'(div0), 32'(vecs[i].d0));
        end

        // Back-to-back: restart from DONE while the previous result is still shown.
        run_op(8'd255, 8'd1, lat);
        check("b2b_first_quot", 32'(Quotient), 255);
        @(negedge clock);
        N = 8'd5;
        D = 8'd9;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        $display("restart edge: busy=%0d ready=%0d q=%0d", busy, ready, Quotient);
        check("b2b_restart_busy", 32'(busy), 1);
        check("b2b_restart_ready", 32'(ready), 0);
        check("b2b_held_quot", 32'(Quotient), 255);
        lat = 1;
        while (!ready && lat < 40) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        check("b2b_lat", 32'(lat), 9);
        check("b2b_quot", 32'(Quotient), 0);
        check("b2b_rem", 32'(Remainder), 5);

        // start re-pulsed during RUN must be ignored.
        @(negedge clock);
        N = 8'd255;
        D = 8'd255;
        start = 1'b1;
        @(posedge clock);
        lat = 1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        N = 8'd0;
        D = 8'd13;
        start = 1'b1;
        @(posedge clock);
        lat++;
        @(negedge clock);
        start = 1'b0;
        while (!ready && lat < 40) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        $display("ignored restart: q=%0d r=%0d lat=%0d", Quotient, Remainder, lat);
        check("ign_lat", 32'(lat), 9);
        check("ign_quot", 32'(Quotient), 1);
        check("ign_rem", 32'(Remainder), 0);

        // Asynchronous reset in the middle of RUN.
        @(negedge clock);
        N = 8'd100;
        D = 8'd7;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        n_reset = 1'b0;
        #1;
        $display("mid-run reset: busy=%0d ready=%0d q=%0d r=%0d", busy, ready, Quotient, Remainder);
        check("arst_busy", 32'(busy), 0);
        check("arst_ready", 32'(ready), 0);
        check("arst_div0", 32'(div0), 0);
        check("arst_quot", 32'(Quotient), 0);
        check("arst_rem", 32'(Remainder), 0);
        @(negedge clock);
        @(negedge clock);
        check("arst_hold_busy", 32'(busy), 0);
        n_reset = 1'b1;
        run_op(8'd60, 8'd8, lat);
        check("post_rst_lat", 32'(lat), 9);
        check("post_rst_quot", 32'(Quotient), 7);
        check("post_rst_rem", 32'(Remainder), 4);

        // Random sweep against the bench's own arithmetic.
        for (int k = 0; k < 1000; k++) begin
            rn = 8'($urandom);
            rd = 8'($urandom_range(1, 255));
            run_op(rn, rd, lat);
            $display("rnd %0d/%0d -> q=%0d r=%0d lat=%0d", rn, rd, Quotient, Remainder, lat);
            check("rnd_lat", 32'(lat), 9);
            check("rnd_quot", 32'(Quotient), 32'(rn / rd));
            check("rnd_rem", 32'(Remainder), 32'(rn % rd));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_divider
